fir_mac_seq: RTL

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_seq_if.sv | 31 +++
 rtl/fir_mac_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if -- bundle of the sample, coefficient and result handshakes
// of the sequential FIR filter.
//   master : producer/consumer side (drives samples, coefficients, out_ready)
//   slave  : filter side (drives in_ready, out_valid, out_data)
// Parameters mirror the filter so both ends agree on widths.
interface fir_mac_seq_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
);
    logic                         in_valid;
    logic signed [DATA_W-1:0]     in_data;
    logic                         in_ready;
    logic                         coef_we;
    logic [$clog2(TAPS)-1:0]      coef_addr;
    logic signed [COEF_W-1:0]     coef_data;
    logic                         out_valid;
    logic signed [ACC_W-1:0]      out_data;
    logic                         out_ready;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac_seq.sv
// fir_mac_seq -- sequential FIR filter sharing one signed multiplier across
// all taps, one product per clock.
//   clk       : sole clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : fir_mac_seq_if.slave
//               in_valid/in_data/in_ready    sample handshake (accepted in IDLE)
//               coef_we/coef_addr/coef_data  coefficient write port (IDLE only)
//               out_valid/out_data/out_ready result handshake (held in DONE)
// Optional feature macro: MAC_PIPE_EN registers the multiplier output ahead of
// the accumulator and adds a DRAIN state for the final product (one extra
// cycle of latency, identical results).
module fir_mac_seq #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic         clk,
    input  logic         rst,
    fir_mac_seq_if.slave bus
);
    localparam int K_W = $clog2(TAPS);
    localparam int P_W = DATA_W + COEF_W;
    localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

`ifdef MAC_PIPE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2, DRAIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t                   state_r;
    logic [K_W-1:0]           k_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [DATA_W-1:0] x_r [TAPS];
    logic signed [COEF_W-1:0] c_r [TAPS];
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic signed [ACC_W-1:0]  out_data_r;
`ifdef MAC_PIPE_EN
    logic signed [ACC_W-1:0]  prod_r;
`endif

    logic signed [P_W-1:0]    prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic                     addr_ok_s;
    logic                     coef_wr_s;

    // Shared multiplier for the current tap; the result is sign-extended
    // (or wrapped) to accumulator width.
    always_comb begin
        prod_s     = P_W'(x_r[k_r]) * P_W'(c_r[k_r]);
        prod_ext_s = ACC_W'(prod_s);
    end

    // Address range check; with a power-of-two tap count every address is legal.
    generate
        if ((1 << K_W) == TAPS) begin : g_addr_full
            assign addr_ok_s = 1'b1;
        end else begin : g_addr_part
            assign addr_ok_s = (32'(bus.coef_addr) < 32'(TAPS));
        end
    endgenerate

    // Coefficients may only change while no pass is running.
    always_comb begin
        coef_wr_s = bus.coef_we && addr_ok_s && (state_r == IDLE);
    end

    // Sequencer: accept, multiply-accumulate per tap, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= '0;
            acc_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
`ifdef MAC_PIPE_EN
            prod_r      <= '0;
`endif
            for (int i = 0; i < TAPS; i++) begin
                x_r[i] <= '0;
                c_r[i] <= '0;
            end
        end else begin
            // Written before the pass starts, so a same-cycle accept sees it.
            if (coef_wr_s) begin
                c_r[bus.coef_addr] <= bus.coef_data;
            end

            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_r[0] <= bus.in_data;
                        for (int i = 1; i < TAPS; i++) begin
                            x_r[i] <= x_r[i-1];
                        end
                        acc_r      <= '0;
                        k_r        <= '0;
`ifdef MAC_PIPE_EN
                        prod_r     <= '0;
`endif
                        in_ready_r <= 1'b0;
                        state_r    <= MAC;
                    end
                end
                MAC: begin
                    k_r <= k_r + K_W'(1);
`ifdef MAC_PIPE_EN
                    // Adder lags the multiplier by one tap; DRAIN adds the last.
                    prod_r <= prod_ext_s;
                    acc_r  <= acc_r + prod_r;
                    if (k_r == K_LAST) begin
                        state_r <= DRAIN;
                    end
`else
                    acc_r <= acc_r + prod_ext_s;
                    if (k_r == K_LAST) begin
                        out_data_r  <= acc_r + prod_ext_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
`endif
                end
`ifdef MAC_PIPE_EN
                DRAIN: begin
                    acc_r       <= acc_r + prod_r;
                    out_data_r  <= acc_r + prod_r;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
endmodule
